// File: rtl/unet_pvm_top_sdiv_26s_8ns_18_seq.sv
// Iterative restoring divider: signed dividend / unsigned divisor, one quotient bit per clock.
// Produces a saturated signed quotient and a dividend-signed remainder, with a valid/ready handshake on each side.
module unet_pvm_top_sdiv_26s_8ns_18_seq #(
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 18,
  parameter int rem_WIDTH  = din1_WIDTH + 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [rem_WIDTH-1:0]  rem,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int CW = $clog2(din0_WIDTH);

  // Magnitude limits of the signed quotient, expressed on the unsigned quotient
  localparam logic [din0_WIDTH-1:0] POS_LIM =
    {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic [din0_WIDTH-1:0] NEG_LIM =
    {{(din0_WIDTH-dout_WIDTH){1'b0}}, 1'b1, {(dout_WIDTH-1){1'b0}}};
  localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [din0_WIDTH-1:0] dvd;   // dividend bits shift out, quotient bits shift in
  logic [din1_WIDTH-1:0] dsr;
  logic [din1_WIDTH-1:0] pr;
  logic                  neg;
  logic [CW-1:0]         cnt;

  logic [din0_WIDTH-1:0] din0_abs;
  logic [din1_WIDTH:0]   pr_sh;
  logic [din1_WIDTH-1:0] pr_diff;
  logic                  qbit;
  logic [din1_WIDTH-1:0] pr_nxt;
  logic [din0_WIDTH-1:0] dvd_nxt;

  logic                  ovf_pos, ovf_neg;
  logic [dout_WIDTH-1:0] q_trunc;
  logic [dout_WIDTH-1:0] q_res;
  logic [rem_WIDTH-1:0]  r_ext;
  logic [rem_WIDTH-1:0]  r_res;

  // -2^(W-1) negates to itself, which reads correctly as 2^(W-1) unsigned
  assign din0_abs = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;

  // One restoring step; the true difference fits in din1_WIDTH bits whenever it is taken
  assign pr_sh   = {pr, dvd[din0_WIDTH-1]};
  assign qbit    = (pr_sh >= {1'b0, dsr});
  assign pr_diff = pr_sh[din1_WIDTH-1:0] - dsr;
  assign pr_nxt  = qbit ? pr_diff : pr_sh[din1_WIDTH-1:0];
  assign dvd_nxt = {dvd[din0_WIDTH-2:0], qbit};

  assign ovf_pos = !neg && (dvd_nxt > POS_LIM);
  assign ovf_neg =  neg && (dvd_nxt > NEG_LIM);
  assign q_trunc = dvd_nxt[dout_WIDTH-1:0];
  assign r_ext   = {1'b0, pr_nxt};

  always_comb begin
    q_res = neg ? (~q_trunc + 1'b1) : q_trunc;
    if (ovf_pos) q_res = Q_MAX;
    if (ovf_neg) q_res = Q_MIN;
    r_res = neg ? (~r_ext + 1'b1) : r_ext;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (din1 == '0) ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dvd  <= '0;
      dsr  <= '0;
      pr   <= '0;
      neg  <= 1'b0;
      cnt  <= '0;
      dout <= '0;
      rem  <= '0;
      ovf  <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd <= din0_abs;
          dsr <= din1;
          neg <= din0[din0_WIDTH-1];
          pr  <= '0;
          cnt <= CW'(din0_WIDTH - 1);
          if (din1 == '0) begin
            dout <= din0[din0_WIDTH-1] ? Q_MIN : Q_MAX;
            rem  <= '0;
            ovf  <= 1'b0;
            dbz  <= 1'b1;
          end
        end
        CALC: begin
          dvd <= dvd_nxt;
          pr  <= pr_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            dout <= q_res;
            rem  <= r_res;
            ovf  <= ovf_pos | ovf_neg;
            dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unet_pvm_top_sdiv_26s_8ns_18_seq.sv
// Bench for the sequential signed divider: directed table, backpressure, mid-op reset, random vs. an arithmetic model.
module tb_unet_pvm_top_sdiv_26s_8ns_18_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [25:0] din0 = '0;
  logic [7:0]  din1 = '0;
  logic        in_ready, out_valid, ovf, dbz;
  logic [17:0] dout;
  logic [8:0]  rem;

  int tests = 0;
  int fails = 0;

  unet_pvm_top_sdiv_26s_8ns_18_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .rem(rem), .ovf(ovf), .dbz(dbz)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int a; int b; int q; int r; bit o; bit z; int lat;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: language division truncates toward zero and the remainder follows the dividend
  function automatic void model(input int a, input int b, output int q, output int r,
                                output bit o, output bit z);
    z = (b == 0);
    o = 1'b0;
    if (z) begin
      q = (a < 0) ? -131072 : 131071;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 131071) begin q = 131071; o = 1'b1; end
      else if (q < -131072) begin q = -131072; o = 1'b1; end
    end
  endfunction

  task automatic do_op(input string nm, input int a, input int b, input int q, input int r,
                       input bit o, input bit z, input int lat, input int stall);
    int n;
    @(negedge ap_clk);
    din0 = a[25:0];
    din1 = b[7:0];
    in_valid = 1'b1;
    chk({nm, " in_ready"}, longint'(in_ready), 1);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " dout"}, longint'($signed(dout)), q);
    chk({nm, " rem"}, longint'($signed(rem)), r);
    chk({nm, " ovf/dbz"}, longint'({ovf, dbz}), longint'({o, z}));
    repeat (stall) @(posedge ap_clk);
    #1;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk({nm, " out_valid drop"}, longint'(out_valid), 0);
    chk({nm, " dout held"}, longint'($signed(dout)), q);
  endtask

  initial begin
    vec_t vecs[7];
    bit   bad;
    bit   seen;
    int   q, r;
    bit   o, z;

    vecs[0] = '{a: 1000,      b: 7,   q: 142,     r: 6,  o: 0, z: 0, lat: 27};
    vecs[1] = '{a: -1000,     b: 7,   q: -142,    r: -6, o: 0, z: 0, lat: 27};
    vecs[2] = '{a: -5,        b: 9,   q: 0,       r: -5, o: 0, z: 0, lat: 27};
    vecs[3] = '{a: 33554431,  b: 1,   q: 131071,  r: 0,  o: 1, z: 0, lat: 27};
    vecs[4] = '{a: -33554432, b: 255, q: -131072, r: -2, o: 1, z: 0, lat: 27};
    vecs[5] = '{a: 500,       b: 0,   q: 131071,  r: 0,  o: 0, z: 1, lat: 1};
    vecs[6] = '{a: -500,      b: 0,   q: -131072, r: 0,  o: 0, z: 1, lat: 1};

    #12;
    chk("reset in_ready", longint'(in_ready), 1);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset outputs", longint'({dout, rem, ovf, dbz}), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
            vecs[i].o, vecs[i].z, vecs[i].lat, i % 3);

    // Backpressure: results and in_ready must freeze; new in_valid is ignored
    @(negedge ap_clk);
    din0 = 26'd1000; din1 = 8'd7; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (26) @(posedge ap_clk);
    #1;
    chk("bp out_valid", longint'(out_valid), 1);
    din0 = 26'd12345; din1 = 8'd3; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge ap_clk); #1;
      bad = !out_valid || in_ready || ($signed(dout) != 142) || ($signed(rem) != 6) || ovf || dbz;
      chk($sformatf("bp stable c%0d", c), longint'(bad), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk("bp release out_valid", longint'(out_valid), 0);
    do_op("255/255", 255, 255, 1, 0, 0, 0, 27, 0);

    // Reset 10 cycles into CALC aborts with no result
    @(negedge ap_clk);
    din0 = 26'd1000; din1 = 8'd7; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    chk("rst out_valid", longint'(out_valid), 0);
    chk("rst in_ready", longint'(in_ready), 1);
    chk("rst dout", longint'(dout), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge ap_clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst no result", longint'(seen), 0);
    do_op("post-rst 1000/7", 1000, 7, 142, 6, 0, 0, 27, 0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [25:0] t;
      int a, b;
      t = 26'($urandom);
      if (i % 4 == 1) t = 26'($signed(16'($urandom)));
      a = int'($signed(t));
      b = (i % 10 == 7) ? 0 : int'($urandom_range(1, 255));
      model(a, b, q, r, o, z);
      do_op($sformatf("rnd%0d %0d/%0d", i, a, b), a, b, q, r, o, z, z ? 1 : 27,
            int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
